uart_rx_deserializer: RTL and testbench

Receive-side stage that consumes the serial `rx` line of the UART interface and turns it into parallel bytes. It oversamples `rx` at 16x the bit rate, using ticks derived from `pclk` through a programmable divider. Each received frame is delivered on a valid/ready handshake, together with framing-error and parity-error status. It sits between the interface `rx` pin and the agent/monitor-side byte consumer.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_tick_gen.sv | 29 ++
 rtl/uart_rx_deserializer.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserializer.
// Majority voting is enabled by defining UART_RX_MAJORITY_VOTE_EN.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int VOTE_LO    = 6;
    localparam int VOTE_HI    = 8;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DECIDE_TICK = VOTE_HI;
`else
    localparam int DECIDE_TICK = MID_TICK;
`endif

    // Expected parity bit for up to 8 data bits; narrower words arrive zero-extended.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one pclk-wide pulse every max(baud_div,1) cycles,
// realigned to zero whenever restart is asserted.
module uart_rx_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             pclk,
    input  logic             areset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             restart,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] term;

    assign term = (baud_div == '0) ? '0 : baud_div - 1'b1;
    assign tick = (cnt == term);

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 16x oversampled rx line to parallel frames on a valid/ready handshake.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting over ticks 6..8 of each bit.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic [DIV_W-1:0]      baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);

    import uart_rx_pkg::*;

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] DECIDE_IDX  = TICK_W'(DECIDE_TICK);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    uart_rx_state_e state, next_state;

    logic                  rx_meta, rx_sync, rx_prev;
    logic                  tick, restart, start_edge;
    logic                  bit_end, decide, bit_val;
    logic                  shift_en, par_chk, complete;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DIV_W-1:0]      cfg_div;
    logic                  cfg_par_en, cfg_par_odd;
    logic                  par_err_q;

    // Synchronizer plus one extra stage to see the 1->0 transition.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign bit_end    = tick && (tick_cnt == LAST_TICK);
    assign decide     = tick && (tick_cnt == DECIDE_IDX);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_lo, vote_mid;

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            vote_lo  <= 1'b1;
            vote_mid <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == TICK_W'(VOTE_LO))  vote_lo  <= rx_sync;
            if (tick_cnt == TICK_W'(MID_TICK)) vote_mid <= rx_sync;
        end
    end

    assign bit_val = maj3(vote_lo, vote_mid, rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    uart_rx_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .pclk    (pclk),
        .areset  (areset),
        .baud_div(cfg_div),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    restart    = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (decide && bit_val) next_state = IDLE;
                else if (bit_end)      next_state = DATA;
            end
            DATA: begin
                shift_en = decide;
                if (bit_end && (bit_cnt == LAST_BIT))
                    next_state = cfg_par_en ? PARITY : STOP;
            end
            PARITY: begin
                par_chk = decide;
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (decide) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the shift register and config latches are reset too, so no X can reach data_out.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            cfg_div     <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            if (restart) begin
                tick_cnt    <= '0;
                bit_cnt     <= '0;
                cfg_div     <= baud_div;
                cfg_par_en  <= parity_en;
                cfg_par_odd <= parity_odd;
                par_err_q   <= 1'b0;
            end else begin
                if (tick) tick_cnt <= tick_cnt + 1'b1;
                if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            if (par_chk)  par_err_q <= (bit_val != parity_bit(8'(shreg), cfg_par_odd));
        end
    end

    // A pending frame wins over a new one unless it is accepted in the same cycle.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shreg;
                    frame_err  <= ~bit_val;
                    parity_err <= par_err_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus randomized frames
// compared against a frame-level model (honours UART_RX_MAJORITY_VOTE_EN).
module tb_uart_rx_deserializer;

    localparam int DW = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MID = 8;
`else
    localparam int MID = 7;
`endif

    logic          pclk = 1'b0;
    logic          areset;
    logic [15:0]   baud_div;
    logic          parity_en, parity_odd, rx, data_ready;
    logic [DW-1:0] data_out;
    logic          data_valid, frame_err, parity_err, overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .pclk      (pclk),
        .areset    (areset),
        .baud_div  (baud_div),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Transfer log and event counters observed mid-cycle.
    typedef struct {
        logic [DW-1:0] d;
        logic          fe;
        logic          pe;
        int            t;
    } xfer_t;

    xfer_t xq[$];
    int    rise_t     = -1;
    int    ovr_cnt    = 0;
    logic  prev_valid = 1'b0;

    always @(negedge pclk) begin
        #1;
        if (data_valid === 1'b1 && prev_valid !== 1'b1) rise_t = cyc;
        if (data_valid === 1'b1 && data_ready === 1'b1)
            xq.push_back('{d: data_out, fe: frame_err, pe: parity_err, t: cyc});
        if (overrun === 1'b1) ovr_cnt++;
        prev_valid = data_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    // Cycles from driving the start bit to the cycle in which data_valid is first seen:
    // 2 synchronizer stages + edge register, then (bit index * 16 + decide tick + 1) ticks.
    function automatic int exp_off(input int div, input logic pen);
        int deff;
        deff = (div == 0) ? 1 : div;
        return 3 + deff * (16 * (1 + DW + int'(pen)) + MID + 1);
    endfunction

    function automatic logic model_pe(input logic [DW-1:0] d, input logic pen, input logic podd,
                                      input logic pbit);
        int ones;
        ones = $countones(d);
        return pen && (pbit != ((ones % 2 == 1) ^ podd));
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input int div, input logic pen,
                              input logic podd, input logic pbit, input logic stopb,
                              input logic pulse_ready, output int t0);
        int   deff, bl, nb;
        logic bits [0:DW+2];
        deff = (div == 0) ? 1 : div;
        bl   = 16 * deff;
        nb   = DW + 2 + (pen ? 1 : 0);
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        bits[DW+1] = pen ? pbit : stopb;
        bits[DW+2] = stopb;
        baud_div   = 16'(div);
        parity_en  = pen;
        parity_odd = podd;
        repeat (4) @(negedge pclk);
        t0 = cyc;
        for (int c = 0; c < nb * bl; c++) begin
            rx = bits[c/bl];
            if (c == 8) begin
                baud_div   = 16'($urandom);
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
            end
            if (pulse_ready) data_ready = (cyc == t0 + exp_off(div, pen) - 1);
            @(negedge pclk);
        end
        rx = 1'b1;
        if (pulse_ready) data_ready = 1'b0;
        baud_div   = 16'(div);
        parity_en  = pen;
        parity_odd = podd;
    endtask

    task automatic accept_one();
        @(negedge pclk);
        data_ready = 1'b1;
        @(negedge pclk);
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge pclk);
        n_vec++;
        if ({data_out, data_valid, frame_err, parity_err, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got d=%h v=%b fe=%b pe=%b ov=%b, want all 0",
                     data_out, data_valid, frame_err, parity_err, overrun);
        end
        areset = 1'b0;
        repeat (4) @(negedge pclk);
        n_vec++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: data_valid=%b, want 0", data_valid);
        end
    endtask

    task automatic test_basic();
        int t0, e;
        data_ready = 1'b0;
        send_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        e = t0 + exp_off(4, 1'b0);
        n_vec++;
        if ({data_valid, data_out, frame_err, parity_err} !== {1'b1, 8'hA5, 2'b00}) begin
            n_err++;
            $display("FAIL basic_frame: got v=%b d=%h fe=%b pe=%b, want v=1 d=a5 fe=0 pe=0",
                     data_valid, data_out, frame_err, parity_err);
        end
        n_vec++;
        if (rise_t < e - 1 || rise_t > e + 1) begin
            n_err++;
            $display("FAIL basic_latency: valid rose at cycle %0d, want %0d", rise_t, e);
        end
        accept_one();
        n_vec++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_accept: data_valid=%b after transfer, want 0", data_valid);
        end
    endtask

    task automatic test_parity();
        int t0;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h3C, 4, 1'b1, 1'b0, (k == 0), 1'b1, 1'b0, t0);
            n_vec++;
            if ({data_valid, data_out, frame_err, parity_err} !== {1'b1, 8'h3C, 1'b0, (k == 0)}) begin
                n_err++;
                $display("FAIL parity_%0d: got v=%b d=%h fe=%b pe=%b, want v=1 d=3c fe=0 pe=%0d",
                         k, data_valid, data_out, frame_err, parity_err, (k == 0));
            end
            accept_one();
        end
    endtask

    task automatic test_glitch();
        int n0, o0;
        n0 = xq.size();
        o0 = ovr_cnt;
        baud_div  = 16'd4;
        parity_en = 1'b0;
        repeat (4) @(negedge pclk);
        rx = 1'b0;
        repeat (20) @(negedge pclk);
        rx = 1'b1;
        repeat (200) @(negedge pclk);
        n_vec++;
        if (data_valid !== 1'b0 || ovr_cnt != o0) begin
            n_err++;
            $display("FAIL glitch_ignored: v=%b overruns=%0d, want v=0 overruns=%0d",
                     data_valid, ovr_cnt, o0);
        end
        data_ready = 1'b1;
        repeat (2) @(negedge pclk);
        data_ready = 1'b0;
        n_vec++;
        if (xq.size() != n0) begin
            n_err++;
            $display("FAIL glitch_no_frame: %0d transfers seen, want %0d", xq.size(), n0);
        end
    endtask

    task automatic test_frame_err();
        int t0;
        send_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        n_vec++;
        if ({data_valid, data_out, frame_err, parity_err} !== {1'b1, 8'h55, 2'b10}) begin
            n_err++;
            $display("FAIL frame_err: got v=%b d=%h fe=%b pe=%b, want v=1 d=55 fe=1 pe=0",
                     data_valid, data_out, frame_err, parity_err);
        end
        accept_one();
    endtask

    task automatic test_overrun();
        int t0, o0, r0, n0, e;
        xfer_t x;
        data_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        send_frame(8'h22, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        n_vec++;
        if (ovr_cnt != o0 + 1) begin
            n_err++;
            $display("FAIL overrun_pulse: %0d pulses, want 1", ovr_cnt - o0);
        end
        n_vec++;
        if ({data_valid, data_out, frame_err} !== {1'b1, 8'h11, 1'b0}) begin
            n_err++;
            $display("FAIL overrun_keep: got v=%b d=%h fe=%b, want v=1 d=11 fe=0",
                     data_valid, data_out, frame_err);
        end
        r0 = rise_t;
        n0 = xq.size();
        send_frame(8'h33, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
        e = t0 + exp_off(4, 1'b0) - 1;
        n_vec++;
        if ({data_valid, data_out} !== {1'b1, 8'h33} || ovr_cnt != o0 + 1 || rise_t != r0) begin
            n_err++;
            $display("FAIL same_cycle_load: got v=%b d=%h overruns=%0d rise=%0d, want v=1 d=33 overruns=1 rise=%0d",
                     data_valid, data_out, ovr_cnt - o0, rise_t, r0);
        end
        n_vec++;
        if (xq.size() != n0 + 1) begin
            n_err++;
            $display("FAIL same_cycle_xfer: %0d transfers, want 1", xq.size() - n0);
        end else begin
            x = xq[xq.size()-1];
            n_vec++;
            if (x.d !== 8'h11 || x.t != e) begin
                n_err++;
                $display("FAIL same_cycle_old: took d=%h at cycle %0d, want d=11 at %0d", x.d, x.t, e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int    t0, n0, e;
        xfer_t x;
        baud_div  = 16'd4;
        parity_en = 1'b0;
        repeat (4) @(negedge pclk);
        rx = 1'b0;
        repeat (64) @(negedge pclk);
        rx = 1'b1;
        repeat (64) @(negedge pclk);
        rx = 1'b0;
        repeat (128) @(negedge pclk);
        repeat (32) @(negedge pclk);
        areset = 1'b1;
        #1;
        n_vec++;
        if ({data_out, data_valid, frame_err, parity_err, overrun} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got d=%h v=%b fe=%b pe=%b ov=%b, want all 0",
                     data_out, data_valid, frame_err, parity_err, overrun);
        end
        rx = 1'b1;
        repeat (3) @(negedge pclk);
        areset     = 1'b0;
        data_ready = 1'b1;
        n0 = xq.size();
        send_frame(8'h81, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t0);
        data_ready = 1'b0;
        e = t0 + exp_off(4, 1'b0);
        n_vec++;
        if (xq.size() != n0 + 1) begin
            n_err++;
            $display("FAIL after_reset_count: %0d transfers, want 1", xq.size() - n0);
        end else begin
            x = xq[xq.size()-1];
            n_vec++;
            if ({x.d, x.fe, x.pe} !== {8'h81, 2'b00} || x.t < e - 1 || x.t > e + 1) begin
                n_err++;
                $display("FAIL after_reset_frame: got d=%h fe=%b pe=%b t=%0d, want d=81 fe=0 pe=0 t=%0d",
                         x.d, x.fe, x.pe, x.t, e);
            end
        end
    endtask

    task automatic test_random();
        int            t0, n0, e, div;
        logic [DW-1:0] d;
        logic          pen, podd, pbit, stopb, epe;
        xfer_t         x;
        data_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            d     = DW'($urandom);
            div   = int'($urandom_range(0, 3));
            pen   = 1'($urandom);
            podd  = 1'($urandom);
            pbit  = 1'($urandom);
            stopb = ($urandom_range(0, 3) != 0);
            epe   = model_pe(d, pen, podd, pbit);
            n0    = xq.size();
            send_frame(d, div, pen, podd, pbit, stopb, 1'b0, t0);
            e = t0 + exp_off(div, pen);
            n_vec++;
            if (xq.size() != n0 + 1) begin
                n_err++;
                $display("FAIL rand_%0d_count: %0d transfers, want 1", k, xq.size() - n0);
            end else begin
                x = xq[xq.size()-1];
                n_vec++;
                if ({x.d, x.fe, x.pe} !== {d, ~stopb, epe} || x.t < e - 1 || x.t > e + 1) begin
                    n_err++;
                    $display("FAIL rand_%0d: got d=%h fe=%b pe=%b t=%0d, want d=%h fe=%b pe=%b t=%0d (div=%0d par=%b odd=%b)",
                             k, x.d, x.fe, x.pe, x.t, d, ~stopb, epe, e, div, pen, podd);
                end
            end
        end
        data_ready = 1'b0;
    endtask

    initial begin
        areset     = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        baud_div   = 16'd4;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        repeat (4) @(negedge pclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
